sram_pio_sequencer: RTL and testbench
=====================================

Name: sram_pio_sequencer

Overview:
Avalon-MM slave that sequences single-byte read/write cycles to an external asynchronous 8-bit SRAM in the sRamQsys system. The Nios core loads address and data registers, then issues a command. The block drives chip-enable, output-enable, write-enable and the bidirectional data bus with programmable setup, pulse and hold timing. It replaces the current manual bit-banging of the SRAM through separate output ports.

Parameters:
ADDR_W, 11, SRAM address width in bits (1..24).
SETUP_CYC, 1, cycles address and data are stable before the strobe (1..15).
PULSE_CYC, 2, cycles the we_n/oe_n strobe is asserted (1..15).
HOLD_CYC, 1, cycles after the strobe before the bus is released (1..15).

Ports:
clk  in  1  system clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
address  in  2  register select: 0 ADDR, 1 DATA, 2 CMD, 3 STATUS
chipselect  in  1  slave select
write_n  in  1  active-low register write strobe
writedata  in  32  register write data
readdata  out  32  combinational register read data
irq  out  1  equals STATUS.done
sram_addr  out  ADDR_W  SRAM address
sram_dq_out  out  8  write data to the bus
sram_dq_oe  out  1  drive enable for sram_dq_out
sram_dq_in  in  8  bus read data
sram_ce_n  out  1  SRAM chip enable, active low
sram_oe_n  out  1  SRAM output enable, active low
sram_we_n  out  1  SRAM write enable, active low

Behaviour:
- Register write: occurs on any edge where chipselect=1 and write_n=0. There is no wait state.
- Reset values: addr_reg=0, wdata_reg=0, rdata_reg=0, busy=0, done=0, err=0, state=IDLE, cnt=0.
- Reset outputs: sram_ce_n=1, sram_oe_n=1, sram_we_n=1, sram_dq_oe=0, irq=0.
- Reset is asynchronous at any point and aborts an in-flight cycle immediately. Strobes deassert and the bus is released with no completion.
- ADDR write: loads writedata[ADDR_W-1:0]. DATA write: loads wdata_reg from writedata[7:0].
- ADDR or DATA write while busy: ignored, and err is set.
- CMD write: bit0 starts a write, bit1 starts a read.
  - Both bits set, or CMD written while busy: no operation, err set.
  - Neither bit set: no effect.
  - Accepted command: busy=1 and done=0 on the next edge.
- STATUS write (any value) clears done and err. If it coincides with a completion edge, done=1 wins; err is still cleared.
- readdata (combinational):
  - 0: addr_reg zero-extended.
  - 1: rdata_reg zero-extended.
  - 2: 0.
  - 3: {29'b0, err, done, busy}.
  - When chipselect=0, readdata follows address anyway, as in the PIO ports.
- FSM states: IDLE, W_SETUP, W_PULSE, W_HOLD, R_SETUP, R_ACCESS, R_HOLD. A 4-bit counter cnt is loaded with N-1 on state entry and the state exits when cnt=0.
- Write sequence:
  - W_SETUP (SETUP_CYC cycles): ce_n=0, we_n=1, dq_oe=1, sram_addr=addr_reg, dq_out=wdata_reg.
  - W_PULSE (PULSE_CYC cycles): we_n=0.
  - W_HOLD (HOLD_CYC cycles): we_n=1, dq_oe=1, ce_n=0.
  - Then IDLE.
- Read sequence:
  - R_SETUP (SETUP_CYC cycles): ce_n=0, oe_n=1, dq_oe=0.
  - R_ACCESS (PULSE_CYC cycles): oe_n=0. rdata_reg captures sram_dq_in on the final R_ACCESS edge.
  - R_HOLD (HOLD_CYC cycles): oe_n=1, ce_n=0.
  - Then IDLE.
- Completion: on the edge leaving *_HOLD, busy=0 and done=1. The block reaches IDLE with ce_n=1 and dq_oe=0.
- Latency: busy is high for exactly SETUP_CYC+PULSE_CYC+HOLD_CYC cycles.
- sram_dq_oe is never 1 while sram_oe_n=0, in any state.
- A new command is accepted on the edge immediately after done rises, so back-to-back operations are allowed.
- Outputs are registered; sram_addr and sram_dq_out are held stable for the whole cycle.

Test Plan:
- Reset: assert reset_n=0 mid-W_PULSE → within the same cycle we_n=1, ce_n=1, dq_oe=0, busy=0; STATUS reads 0.
- Write, default parameters: ADDR=0x123, DATA=0xA5, CMD=1 → ce_n low 4 cycles, we_n low cycles 2-3, dq_out=0xA5, addr=0x123; done=1 and irq=1 after 4 cycles.
- Read: SRAM model returns 0x3C at 0x123, CMD=2 → oe_n low 2 cycles, dq_oe=0 throughout; DATA reads 0x0000003C; STATUS=0x2.
- Errors:
  - CMD=3 → no strobe, STATUS=0x4.
  - CMD=1 while busy → first op completes unchanged; err=1.
  - ADDR write while busy → addr_reg unchanged.
- Clear race: STATUS write on the completion edge → STATUS reads 0x2 afterward.
- Timing sweep: SETUP_CYC=3, PULSE_CYC=1, HOLD_CYC=2 → busy exactly 6 cycles, back-to-back write then read at the max address 0x7FF.

Source files
------------

// File: rtl/sram_pio_sequencer.sv
// Avalon-MM slave that runs single-byte read/write cycles on an external
// asynchronous 8-bit SRAM with programmable setup / pulse / hold timing.
module sram_pio_sequencer #(
    parameter int ADDR_W    = 11,
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 2,
    parameter int HOLD_CYC  = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic              irq,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [7:0]        sram_dq_out,
    output logic              sram_dq_oe,
    input  logic [7:0]        sram_dq_in,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n
);
    typedef enum logic [2:0] {
        IDLE, W_SETUP, W_PULSE, W_HOLD, R_SETUP, R_ACCESS, R_HOLD
    } state_e;

    localparam logic [3:0] SETUP_N = 4'(SETUP_CYC - 1);
    localparam logic [3:0] PULSE_N = 4'(PULSE_CYC - 1);
    localparam logic [3:0] HOLD_N  = 4'(HOLD_CYC - 1);

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        wdata_q, wdata_d, rdata_q, rdata_d;
    logic              done_q, done_d, err_q, err_d;
    logic              ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d, dq_oe_q, dq_oe_d;

    logic reg_wr, wr_addr, wr_data, wr_cmd, wr_status;
    logic busy, last, finish, cmd_wr_ok, cmd_rd_ok, cmd_bad;
    logic unused_wd;

    assign reg_wr    = chipselect & ~write_n;
    assign wr_addr   = reg_wr && (address == 2'd0);
    assign wr_data   = reg_wr && (address == 2'd1);
    assign wr_cmd    = reg_wr && (address == 2'd2);
    assign wr_status = reg_wr && (address == 2'd3);
    assign busy      = (state_q != IDLE);
    assign last      = (cnt_q == 4'd0);
    assign finish    = last && (state_q == W_HOLD || state_q == R_HOLD);
    assign cmd_wr_ok = wr_cmd && !busy && (writedata[1:0] == 2'b01);
    assign cmd_rd_ok = wr_cmd && !busy && (writedata[1:0] == 2'b10);
    // Any CMD write while busy is an error, even with no command bits set.
    assign cmd_bad   = wr_cmd && (busy || writedata[1:0] == 2'b11);
    assign unused_wd = ^writedata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = last ? 4'd0 : cnt_q - 4'd1;
        case (state_q)
            IDLE: begin
                cnt_d = 4'd0;
                if (cmd_wr_ok) begin state_d = W_SETUP; cnt_d = SETUP_N; end
                else if (cmd_rd_ok) begin state_d = R_SETUP; cnt_d = SETUP_N; end
            end
            W_SETUP:  if (last) begin state_d = W_PULSE;  cnt_d = PULSE_N; end
            W_PULSE:  if (last) begin state_d = W_HOLD;   cnt_d = HOLD_N;  end
            W_HOLD:   if (last) begin state_d = IDLE;     cnt_d = 4'd0;    end
            R_SETUP:  if (last) begin state_d = R_ACCESS; cnt_d = PULSE_N; end
            R_ACCESS: if (last) begin state_d = R_HOLD;   cnt_d = HOLD_N;  end
            R_HOLD:   if (last) begin state_d = IDLE;     cnt_d = 4'd0;    end
            default: begin state_d = IDLE; cnt_d = 4'd0; end
        endcase
    end

    // Strobes are decoded from the next state so they are registered yet
    // line up with the state they belong to.
    always_comb begin
        ce_n_d  = (state_d == IDLE);
        we_n_d  = (state_d != W_PULSE);
        oe_n_d  = (state_d != R_ACCESS);
        dq_oe_d = (state_d == W_SETUP) || (state_d == W_PULSE) || (state_d == W_HOLD);
    end

    always_comb begin
        addr_d  = (wr_addr && !busy) ? writedata[ADDR_W-1:0] : addr_q;
        wdata_d = (wr_data && !busy) ? writedata[7:0] : wdata_q;
        rdata_d = (state_q == R_ACCESS && last) ? sram_dq_in : rdata_q;
        done_d  = done_q;
        if (wr_status || cmd_wr_ok || cmd_rd_ok) done_d = 1'b0;
        if (finish) done_d = 1'b1;
        err_d = err_q;
        if (wr_status) err_d = 1'b0;
        if (((wr_addr || wr_data) && busy) || cmd_bad) err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q  <= '0;
            wdata_q <= 8'd0;
            rdata_q <= 8'd0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            dq_oe_q <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
            err_q   <= err_d;
            ce_n_q  <= ce_n_d;
            oe_n_q  <= oe_n_d;
            we_n_q  <= we_n_d;
            dq_oe_q <= dq_oe_d;
        end
    end

    always_comb begin
        case (address)
            2'd0:    readdata = 32'(addr_q);
            2'd1:    readdata = {24'd0, rdata_q};
            2'd2:    readdata = 32'd0;
            default: readdata = {29'd0, err_q, done_q, busy};
        endcase
    end

    assign irq         = done_q;
    assign sram_addr   = addr_q;
    assign sram_dq_out = wdata_q;
    assign sram_ce_n   = ce_n_q;
    assign sram_oe_n   = oe_n_q;
    assign sram_we_n   = we_n_q;
    assign sram_dq_oe  = dq_oe_q;
endmodule

// File: tb/tb_sram_pio_sequencer.sv
// Bench for sram_pio_sequencer: two instances (default timing and 3/1/2 timing)
// driven by randomized register traffic, checked against an SRAM byte model.
module tb_sram_pio_sequencer;
    logic clk = 1'b0, reset_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  address = 2'd3;
    logic        chipselect = 1'b0, write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    int          sel = 0;

    logic [31:0] rd0, rd1;
    logic [10:0] a0, a1;
    logic [7:0]  dqo0, dqo1, dqi0, dqi1;
    logic        irq0, irq1, doe0, doe1, ce0, ce1, oe0, oe1, we0, we1;

    sram_pio_sequencer dut0 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect && sel == 0),
        .write_n(write_n), .writedata(writedata), .readdata(rd0), .irq(irq0),
        .sram_addr(a0), .sram_dq_out(dqo0), .sram_dq_oe(doe0), .sram_dq_in(dqi0),
        .sram_ce_n(ce0), .sram_oe_n(oe0), .sram_we_n(we0));

    sram_pio_sequencer #(.ADDR_W(11), .SETUP_CYC(3), .PULSE_CYC(1), .HOLD_CYC(2)) dut1 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect && sel == 1),
        .write_n(write_n), .writedata(writedata), .readdata(rd1), .irq(irq1),
        .sram_addr(a1), .sram_dq_out(dqo1), .sram_dq_oe(doe1), .sram_dq_in(dqi1),
        .sram_ce_n(ce1), .sram_oe_n(oe1), .sram_we_n(we1));

    // Timing of each instance, as configured above.
    int S[2] = '{1, 3};
    int P[2] = '{2, 1};
    int H[2] = '{1, 2};

    // External SRAM byte model plus an independent reference copy.
    logic [7:0] mem [2][2048];
    logic [7:0] ref_mem [2][2048];
    bit         filled = 1'b0;
    bit         ovr = 1'b0;
    logic [7:0] ovr_val = 8'h00;

    function automatic logic [7:0] fill_val(int i, int s);
        return 8'(i * 7 + s * 13 + 90);
    endfunction

    always @(negedge clk) begin
        if (!filled) begin
            for (int i = 0; i < 2048; i++) begin
                mem[0][i] <= fill_val(i, 0);
                mem[1][i] <= fill_val(i, 1);
            end
            filled <= 1'b1;
        end else begin
            if (!ce0 && !we0) mem[0][a0] <= dqo0;
            if (!ce1 && !we1) mem[1][a1] <= dqo1;
        end
    end

    assign dqi0 = (!ce0 && !oe0) ? (ovr ? ovr_val : mem[0][a0]) : 8'h00;
    assign dqi1 = (!ce1 && !oe1) ? (ovr ? ovr_val : mem[1][a1]) : 8'h00;

    logic [31:0] o_rd;
    logic [10:0] o_addr;
    logic [7:0]  o_dq;
    logic        o_irq, o_doe, o_ce, o_oe, o_we;
    assign o_rd   = sel ? rd1  : rd0;
    assign o_addr = sel ? a1   : a0;
    assign o_dq   = sel ? dqo1 : dqo0;
    assign o_irq  = sel ? irq1 : irq0;
    assign o_doe  = sel ? doe1 : doe0;
    assign o_ce   = sel ? ce1  : ce0;
    assign o_oe   = sel ? oe1  : oe0;
    assign o_we   = sel ? we1  : we0;

    int checks = 0, errors = 0;
    int ce_low, we_low, oe_low, we_first, oe_first, doe_rd, bad_addr, bad_dq, ovl;
    logic [10:0] cur_addr;
    logic [7:0]  exp_data;

    task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        @(posedge clk); #1;
        chipselect = 1'b0; write_n = 1'b1; address = 2'd3;
    endtask

    task automatic rd_reg(input logic [1:0] a, output logic [31:0] d);
        address = a; #1; d = o_rd; address = 2'd3;
    endtask

    // Issue a command and watch the bus cycle-by-cycle until busy drops.
    // inject 1: CMD and ADDR writes while busy; inject 2: STATUS write on the completion edge.
    task automatic do_op(input bit rd, input int inject, output int busy_cyc);
        int k;
        ce_low = 0; we_low = 0; oe_low = 0; we_first = 0; oe_first = 0;
        doe_rd = 0; bad_addr = 0; bad_dq = 0; ovl = 0; busy_cyc = 0;
        wr_reg(2'd2, rd ? 32'd2 : 32'd1);
        for (k = 1; k <= 60; k++) begin
            @(negedge clk);
            chipselect = 1'b0; write_n = 1'b1; address = 2'd3; #1;
            if (!o_ce) ce_low++;
            if (!o_we) begin we_low++; if (we_first == 0) we_first = k; if (o_dq !== exp_data) bad_dq++; end
            if (!o_oe) begin oe_low++; if (oe_first == 0) oe_first = k; end
            if (!o_ce && o_addr !== cur_addr) bad_addr++;
            if (o_doe && !o_oe) ovl++;
            if (rd && o_doe) doe_rd++;
            if (!o_rd[0]) break;
            busy_cyc++;
            if (inject == 1 && k == 1) begin chipselect = 1'b1; write_n = 1'b0; address = 2'd2; writedata = 32'd1; end
            if (inject == 1 && k == 2) begin chipselect = 1'b1; write_n = 1'b0; address = 2'd0; writedata = 32'(cur_addr ^ 11'h7FF); end
            if (inject == 2 && k == S[sel] + P[sel] + H[sel]) begin chipselect = 1'b1; write_n = 1'b0; address = 2'd3; writedata = 32'hFFFF_FFFF; end
        end
        checks++;
        if (k > 60) begin errors++; $display("FAIL op_timeout: busy still set after %0d cycles, required drop", k - 1); end
    endtask

    task automatic test_reset();
        logic [31:0] r;
        checks++;
        if ({o_ce, o_oe, o_we, o_doe, o_irq} !== 5'b11100) begin
            errors++; $display("FAIL reset_outputs: got %b required 11100", {o_ce, o_oe, o_we, o_doe, o_irq});
        end
        rd_reg(2'd3, r); checks++;
        if (r !== 32'd0) begin errors++; $display("FAIL reset_status: got %h required 0", r); end
        rd_reg(2'd0, r); checks++;
        if (r !== 32'd0) begin errors++; $display("FAIL reset_addr: got %h required 0", r); end
        rd_reg(2'd1, r); checks++;
        if (r !== 32'd0) begin errors++; $display("FAIL reset_rdata: got %h required 0", r); end
    endtask

    task automatic test_write();
        int bc;
        logic [31:0] r;
        sel = 0; cur_addr = 11'h123; exp_data = 8'hA5;
        wr_reg(2'd0, 32'h123); wr_reg(2'd1, 32'hA5);
        do_op(1'b0, 0, bc);
        ref_mem[0][11'h123] = 8'hA5;
        checks++; if (bc !== 4) begin errors++; $display("FAIL wr_busy: got %0d required 4", bc); end
        checks++; if (ce_low !== 4) begin errors++; $display("FAIL wr_ce_low: got %0d required 4", ce_low); end
        checks++;
        if (we_low !== 2 || we_first !== 2) begin
            errors++; $display("FAIL wr_we_pulse: got len %0d first %0d required len 2 first 2", we_low, we_first);
        end
        checks++;
        if (bad_addr + bad_dq + ovl !== 0) begin
            errors++; $display("FAIL wr_bus: got addr/data/overlap errs %0d/%0d/%0d required 0", bad_addr, bad_dq, ovl);
        end
        rd_reg(2'd3, r); checks++;
        if (r !== 32'h2 || o_irq !== 1'b1) begin errors++; $display("FAIL wr_done: got status %h irq %b required 2 1", r, o_irq); end
        checks++;
        if (mem[0][11'h123] !== 8'hA5) begin errors++; $display("FAIL wr_sram: got %h required a5", mem[0][11'h123]); end
    endtask

    task automatic test_read();
        int bc;
        logic [31:0] r;
        sel = 0; ovr = 1'b1; ovr_val = 8'h3C;
        do_op(1'b1, 0, bc);
        ovr = 1'b0;
        checks++;
        if (oe_low !== 2 || oe_first !== 2) begin
            errors++; $display("FAIL rd_oe_pulse: got len %0d first %0d required len 2 first 2", oe_low, oe_first);
        end
        checks++;
        if (doe_rd !== 0 || ovl !== 0 || bc !== 4) begin
            errors++; $display("FAIL rd_bus: got dq_oe cycles %0d busy %0d required 0 4", doe_rd, bc);
        end
        rd_reg(2'd1, r); checks++;
        if (r !== 32'h3C) begin errors++; $display("FAIL rd_data: got %h required 3c", r); end
        rd_reg(2'd3, r); checks++;
        if (r !== 32'h2) begin errors++; $display("FAIL rd_status: got %h required 2", r); end
    endtask

    task automatic test_errors();
        int bc, strobes;
        logic [31:0] r;
        sel = 0;
        wr_reg(2'd3, 32'd0);
        wr_reg(2'd2, 32'd3);
        strobes = 0;
        repeat (6) begin @(negedge clk); if (!o_ce || !o_we || !o_oe) strobes++; end
        checks++; if (strobes !== 0) begin errors++; $display("FAIL err_cmd3_strobe: got %0d strobe cycles required 0", strobes); end
        rd_reg(2'd3, r); checks++;
        if (r !== 32'h4) begin errors++; $display("FAIL err_cmd3_status: got %h required 4", r); end
        wr_reg(2'd3, 32'd0);
        cur_addr = 11'h0AA; exp_data = 8'h5A;
        wr_reg(2'd0, 32'h0AA); wr_reg(2'd1, 32'h5A);
        do_op(1'b0, 1, bc);
        ref_mem[0][11'h0AA] = 8'h5A;
        checks++;
        if (bc !== 4 || bad_addr !== 0 || bad_dq !== 0) begin
            errors++; $display("FAIL err_busy_op: got busy %0d addr errs %0d data errs %0d required 4 0 0", bc, bad_addr, bad_dq);
        end
        rd_reg(2'd3, r); checks++;
        if (r !== 32'h6) begin errors++; $display("FAIL err_busy_status: got %h required 6", r); end
        rd_reg(2'd0, r); checks++;
        if (r !== 32'h0AA) begin errors++; $display("FAIL err_busy_addr: got %h required 0aa", r); end
        checks++;
        if (mem[0][11'h0AA] !== 8'h5A) begin errors++; $display("FAIL err_busy_sram: got %h required 5a", mem[0][11'h0AA]); end
    endtask

    task automatic test_clear_race();
        int bc;
        logic [31:0] r;
        sel = 0;
        wr_reg(2'd2, 32'd3);
        cur_addr = 11'h0AA; exp_data = 8'h5A;
        do_op(1'b0, 2, bc);
        rd_reg(2'd3, r); checks++;
        if (r !== 32'h2) begin errors++; $display("FAIL clear_race: got status %h required 2", r); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] r;
        sel = 0; cur_addr = 11'h0AA; exp_data = 8'h5A;
        wr_reg(2'd2, 32'd1);
        @(negedge clk); @(negedge clk); #1;
        checks++; if (o_we !== 1'b0) begin errors++; $display("FAIL rst_mid_pulse: got we_n %b required 0", o_we); end
        #2 reset_n = 1'b0; #1;
        checks++;
        if ({o_we, o_ce, o_doe} !== 3'b110) begin
            errors++; $display("FAIL rst_mid_outputs: got we/ce/oe %b required 110", {o_we, o_ce, o_doe});
        end
        rd_reg(2'd3, r); checks++;
        if (r !== 32'd0) begin errors++; $display("FAIL rst_mid_status: got %h required 0", r); end
        @(negedge clk); reset_n = 1'b1;
    endtask

    task automatic test_random();
        int bc;
        logic [10:0] a;
        logic [7:0]  d;
        bit          rd;
        logic [31:0] r;
        for (int s = 0; s < 2; s++) begin
            sel = s;
            for (int n = 0; n < 8; n++) begin
                a = 11'($urandom_range(0, 2047)); d = 8'($urandom); rd = 1'($urandom_range(0, 1));
                wr_reg(2'd0, 32'(a)); wr_reg(2'd1, 32'(d));
                cur_addr = a; exp_data = d;
                do_op(rd, 0, bc);
                checks++;
                if (bc !== S[s] + P[s] + H[s]) begin errors++; $display("FAIL rnd_busy: got %0d required %0d", bc, S[s] + P[s] + H[s]); end
                checks++;
                if ((rd ? oe_low : we_low) !== P[s] || (rd ? oe_first : we_first) !== S[s] + 1) begin
                    errors++; $display("FAIL rnd_strobe: got len %0d first %0d required %0d %0d",
                        rd ? oe_low : we_low, rd ? oe_first : we_first, P[s], S[s] + 1);
                end
                checks++;
                if (bad_addr + bad_dq + ovl + (rd ? doe_rd : 0) !== 0) begin
                    errors++; $display("FAIL rnd_bus: got addr/data/overlap/oe errs %0d/%0d/%0d/%0d required 0", bad_addr, bad_dq, ovl, doe_rd);
                end
                if (rd) begin
                    rd_reg(2'd1, r); checks++;
                    if (r !== 32'(ref_mem[s][a])) begin errors++; $display("FAIL rnd_read: got %h required %h", r, ref_mem[s][a]); end
                end else begin
                    ref_mem[s][a] = d; checks++;
                    if (mem[s][a] !== d) begin errors++; $display("FAIL rnd_write: got %h required %h", mem[s][a], d); end
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int bc;
        logic [7:0]  d;
        logic [31:0] r;
        sel = 1; d = 8'($urandom); cur_addr = 11'h7FF; exp_data = d;
        wr_reg(2'd0, 32'h7FF); wr_reg(2'd1, 32'(d));
        do_op(1'b0, 0, bc);
        ref_mem[1][11'h7FF] = d;
        checks++;
        if (bc !== 6 || bad_addr + bad_dq !== 0) begin
            errors++; $display("FAIL b2b_write: got busy %0d bus errs %0d required 6 0", bc, bad_addr + bad_dq);
        end
        do_op(1'b1, 0, bc);
        checks++;
        if (bc !== 6 || oe_low !== 1 || oe_first !== 4 || doe_rd !== 0) begin
            errors++; $display("FAIL b2b_read: got busy %0d oe len %0d first %0d dq_oe %0d required 6 1 4 0", bc, oe_low, oe_first, doe_rd);
        end
        rd_reg(2'd1, r); checks++;
        if (r !== 32'(ref_mem[1][11'h7FF])) begin errors++; $display("FAIL b2b_data: got %h required %h", r, ref_mem[1][11'h7FF]); end
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) begin
            ref_mem[0][i] = fill_val(i, 0);
            ref_mem[1][i] = fill_val(i, 1);
        end
        repeat (3) @(negedge clk);
        test_reset();
        reset_n = 1'b1;
        @(negedge clk);
        test_write();
        test_read();
        test_errors();
        test_clear_race();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
